nes_multi_reader: RTL and testbench

- Parametrised serial game-pad reader; successor to the single-controller NES FSM.
- Drives one shared latch and one shared clock to N_CTRL controllers.
- Shifts N_BITS per controller: 8 for NES, 16 for SNES.
- Generates bit timing internally and publishes an atomic parallel button snapshot with a one-cycle valid strobe. The strobe feeds the pong paddle logic once per poll.

---
 rtl/nes_pkg.sv | 29 ++
 rtl/nes_half_period_timer.sv | 29 ++
 rtl/nes_multi_reader.sv | 140 ++++++++++++++
 tb/tb_nes_multi_reader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared types and constants for the serial game-pad reader.
// No logic; state encoding, button bit positions and transfer length helper.
// Imported by nes_multi_reader and its timer.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } nes_state_t;

  // Bit positions within one controller's snapshot (first bit shifted = A).
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // clk cycles from LATCH entry to DONE entry.
  function automatic int xfer_cycles(input int n_bits, input int half_period);
    return (2 * n_bits + 1) * half_period;
  endfunction

endpackage

// File: rtl/nes_half_period_timer.sv
// Loadable down-counter that times each reader state; zero flags the last cycle.
// Latency: load takes effect on the next clk; a load of D-1 yields D cycles until zero.
// No backpressure; free-running until it reaches zero and then holds.
module nes_half_period_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load on request, otherwise count down and stick at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/nes_multi_reader.sv
// Polls N_CTRL serial pads over one shared latch/clock and publishes an atomic snapshot.
// Latency: valid fires (2*N_BITS+1)*HALF_PERIOD+1 cycles after poll_tick is sampled in IDLE.
// No backpressure: poll_tick while busy is dropped. Optional NES_EDGE_DETECT_EN adds pressed_pulse.
module nes_multi_reader
  import nes_pkg::*;
#(
  parameter int N_CTRL      = 2,
  parameter int N_BITS      = 8,
  parameter int HALF_PERIOD = 150
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     poll_tick,
  input  logic [N_CTRL-1:0]        nes_data,
  output logic                     nes_latch,
  output logic                     nes_clk,
  output logic                     busy,
  output logic [N_CTRL*N_BITS-1:0] buttons,
  output logic                     valid,
  output logic [N_CTRL*N_BITS-1:0] pressed_pulse
);

  localparam int SNAP_W = N_CTRL * N_BITS;
  localparam int TW     = $clog2(HALF_PERIOD * 2);
  localparam int IW     = $clog2(N_BITS);

  localparam logic [TW-1:0] LD_LATCH = TW'(2 * HALF_PERIOD - 1);
  localparam logic [TW-1:0] LD_HALF  = TW'(HALF_PERIOD - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_BITS - 1);

  nes_state_t        state_q, state_d;
  logic [IW-1:0]     idx_q;
  logic [SNAP_W-1:0] shift_q, shift_d;
  logic [SNAP_W-1:0] buttons_q;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_zero;
  logic              sample;

  nes_half_period_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state, timer reload on every state change, and decoded pad outputs.
  always_comb begin
    state_d   = state_q;
    sample    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    nes_latch = 1'b0;
    nes_clk   = 1'b0;
    busy      = 1'b1;
    valid     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (poll_tick) state_d = LATCH;
      end
      LATCH: begin
        nes_latch = 1'b1;
        if (tmr_zero) state_d = LOW;
      end
      LOW: begin
        if (tmr_zero) begin
          sample  = 1'b1;
          state_d = (idx_q == IDX_LAST) ? DONE : HIGH;
        end
      end
      HIGH: begin
        nes_clk = 1'b1;
        if (tmr_zero) state_d = LOW;
      end
      DONE: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tmr_load = (state_d != state_q);
    case (state_d)
      LATCH:     tmr_val = LD_LATCH;
      LOW, HIGH: tmr_val = LD_HALF;
      default:   tmr_val = '0;
    endcase
  end

  // Capture the current bit of every controller in parallel (pads drive active-low).
  always_comb begin
    shift_d = shift_q;
    if (sample) begin
      for (int c = 0; c < N_CTRL; c++) begin
        shift_d[c * N_BITS + int'(idx_q)] = ~nes_data[c];
      end
    end
  end

  // State, bit index, shift registers; snapshot is loaded on DONE entry so it lines up with valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      if (state_q == IDLE && state_d == LATCH) idx_q <= '0;
      else if (state_q == HIGH && tmr_zero)    idx_q <= idx_q + IW'(1);
      if (state_d == DONE) buttons_q <= shift_d;
    end
  end

  assign buttons = buttons_q;

`ifdef NES_EDGE_DETECT_EN
  logic [SNAP_W-1:0] pressed_q;

  // buttons_q still holds the previous snapshot when DONE is entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pressed_q <= '0;
    end else if (state_d == DONE) begin
      pressed_q <= shift_d & ~buttons_q;
    end else begin
      pressed_q <= '0;
    end
  end

  assign pressed_pulse = pressed_q;
`else
  assign pressed_pulse = '0;
`endif

endmodule

// File: tb/tb_nes_multi_reader.sv
module tb_nes_multi_reader;
  import nes_pkg::*;

`ifdef NES_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: two NES pads, fast timing
  logic        poll_a = 1'b0;
  logic [1:0]  data_a;
  logic        latch_a, nclk_a, busy_a, valid_a;
  logic [15:0] btn_a, pp_a;
  // DUT B: one SNES pad
  logic        poll_b = 1'b0;
  logic [0:0]  data_b;
  logic        latch_b, nclk_b, busy_b, valid_b;
  logic [15:0] btn_b, pp_b;

  nes_multi_reader #(.N_CTRL(2), .N_BITS(8), .HALF_PERIOD(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .poll_tick(poll_a), .nes_data(data_a),
    .nes_latch(latch_a), .nes_clk(nclk_a), .busy(busy_a), .buttons(btn_a),
    .valid(valid_a), .pressed_pulse(pp_a)
  );

  nes_multi_reader #(.N_CTRL(1), .N_BITS(16), .HALF_PERIOD(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .poll_tick(poll_b), .nes_data(data_b),
    .nes_latch(latch_b), .nes_clk(nclk_b), .busy(busy_b), .buttons(btn_b),
    .valid(valid_b), .pressed_pulse(pp_b)
  );

  // Behavioural pads: latch reloads, each rising serial clock advances one bit.
  logic [7:0]  pad_a0 = 8'h00, pad_a1 = 8'h00;
  logic [15:0] pad_b = 16'h0000;
  logic [4:0]  pos_a = 5'd0, pos_b = 5'd0;
  always @(posedge nclk_a or posedge latch_a) pos_a = latch_a ? 5'd0 : pos_a + 5'd1;
  always @(posedge nclk_b or posedge latch_b) pos_b = latch_b ? 5'd0 : pos_b + 5'd1;
  assign data_a = {~pad_a1[pos_a[2:0]], ~pad_a0[pos_a[2:0]]};
  assign data_b = ~pad_b[pos_b[3:0]];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One poll on DUT A starting in cycle 0; optional extra tick or continuous hold.
  task automatic run_a(input int tick2, input bit hold, input int ncyc,
                       output int v_cyc, output int v2_cyc, output int n_valid,
                       output int latch_cyc, output int clk_rise, output int clk_hi,
                       output logic [15:0] btn_v, output logic [15:0] pp_v,
                       output int pp_off, output int btn_glitch, output int busy_after);
    logic prev_clk;
    logic [15:0] prev_btn;
    v_cyc = -1; v2_cyc = -1; n_valid = 0; latch_cyc = 0; clk_rise = 0; clk_hi = 0;
    btn_v = '0; pp_v = '0; pp_off = 0; btn_glitch = 0; busy_after = -1;
    prev_clk = nclk_a;
    prev_btn = btn_a;
    poll_a = 1'b1;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      step();
      poll_a = hold || (cyc == tick2);
      if (latch_a) latch_cyc++;
      if (nclk_a) clk_hi++;
      if (nclk_a && !prev_clk) clk_rise++;
      if (valid_a) begin
        n_valid++;
        if (v_cyc < 0) begin
          v_cyc = cyc; btn_v = btn_a; pp_v = pp_a;
        end else if (v2_cyc < 0) begin
          v2_cyc = cyc;
        end
      end else begin
        if (pp_a != 16'h0) pp_off++;
        if (btn_a != prev_btn) btn_glitch++;
      end
      if (v_cyc >= 0 && cyc == v_cyc + 1) busy_after = busy_a;
      prev_clk = nclk_a;
      prev_btn = btn_a;
    end
    poll_a = 1'b0;
  endtask

  int v_cyc, v2_cyc, n_valid, latch_cyc, clk_rise, clk_hi, pp_off, btn_glitch, busy_after;
  logic [15:0] btn_v, pp_v;

  initial begin
    // Reset state
    reset_n = 1'b0;
    step(); step();
    chk("rst_latch", latch_a, 0);
    chk("rst_nclk", nclk_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_buttons", btn_a, 16'h0);
    chk("rst_pressed", pp_a, 16'h0);
    chk("rst_buttons_b", btn_b, 16'h0);
    reset_n = 1'b1;
    step();

    // Timing and channel mapping: ctrl0 A+RIGHT, ctrl1 START
    pad_a0 = 8'((1 << BTN_A) | (1 << BTN_RIGHT));
    pad_a1 = 8'(1 << BTN_START);
    run_a(0, 1'b0, 90, v_cyc, v2_cyc, n_valid, latch_cyc, clk_rise, clk_hi,
          btn_v, pp_v, pp_off, btn_glitch, busy_after);
    chk("t2_valid_cycle", v_cyc, 69);
    chk("t2_valid_count", n_valid, 1);
    chk("t2_latch_cycles", latch_cyc, 8);
    chk("t2_clk_pulses", clk_rise, 7);
    chk("t2_clk_high_cycles", clk_hi, 28);
    chk("t3_buttons", btn_v, 16'h0881);
    chk("t3_pressed", pp_v, EDGE ? 16'h0881 : 16'h0);
    chk("t3_pressed_off_valid", pp_off, 0);
    chk("t3_buttons_stable", btn_glitch, 0);
    chk("t2_busy_after_valid", busy_after, 0);

    // Second tick 10 cycles in is dropped
    pad_a0 = 8'((1 << BTN_B) | (1 << BTN_UP));
    pad_a1 = 8'((1 << BTN_LEFT) | (1 << BTN_RIGHT));
    run_a(10, 1'b0, 110, v_cyc, v2_cyc, n_valid, latch_cyc, clk_rise, clk_hi,
          btn_v, pp_v, pp_off, btn_glitch, busy_after);
    chk("t4_valid_count", n_valid, 1);
    chk("t4_valid_cycle", v_cyc, 69);
    chk("t4_busy_after_valid", busy_after, 0);
    chk("t4_buttons", btn_v, 16'hC012);
    chk("t4_pressed", pp_v, EDGE ? 16'hC012 : 16'h0);
    chk("t4_latch_cycles", latch_cyc, 8);

    // Continuous poll_tick: one IDLE cycle between DONE and next LATCH
    run_a(0, 1'b1, 150, v_cyc, v2_cyc, n_valid, latch_cyc, clk_rise, clk_hi,
          btn_v, pp_v, pp_off, btn_glitch, busy_after);
    chk("bb_first_valid", v_cyc, 69);
    chk("bb_second_valid", v2_cyc, 139);
    chk("bb_idle_between", busy_after, 0);
    chk("bb_pressed_repeat", pp_v, 16'h0);
    repeat (80) step();
    chk("bb_drained_busy", busy_a, 0);

    // Reset in the middle of the first HIGH phase
    poll_a = 1'b1;
    step();
    poll_a = 1'b0;
    repeat (13) step();
    chk("t1_pre_nclk_high", nclk_a, 1);
    chk("t1_pre_busy", busy_a, 1);
    reset_n = 1'b0;
    step();
    chk("t1_latch", latch_a, 0);
    chk("t1_nclk", nclk_a, 0);
    chk("t1_busy", busy_a, 0);
    chk("t1_valid", valid_a, 0);
    chk("t1_buttons", btn_a, 16'h0);
    reset_n = 1'b1;
    begin
      int stray = 0;
      for (int i = 0; i < 100; i++) begin
        step();
        if (valid_a || busy_a || btn_a != 16'h0) stray++;
      end
      chk("t1_no_resume", stray, 0);
    end

    // SNES width on DUT B: alternating pattern, bit0 pressed
    pad_b = 16'h5555;
    begin
      int vb = -1, nvb = 0, rises = 0, lat = 0;
      logic pc;
      logic [15:0] bb = '0, pb = '0;
      pc = nclk_b;
      poll_b = 1'b1;
      for (int cyc = 1; cyc <= 100; cyc++) begin
        step();
        poll_b = 1'b0;
        if (latch_b) lat++;
        if (nclk_b && !pc) rises++;
        pc = nclk_b;
        if (valid_b) begin
          nvb++;
          if (vb < 0) begin vb = cyc; bb = btn_b; pb = pp_b; end
        end
      end
      chk("t5_valid_cycle", vb, 67);
      chk("t5_valid_count", nvb, 1);
      chk("t5_buttons", bb, 16'h5555);
      chk("t5_clk_pulses", rises, 15);
      chk("t5_latch_cycles", lat, 4);
      chk("t5_pressed", pb, EDGE ? 16'h5555 : 16'h0);
      chk("t5_busy_after", busy_b, 0);
    end

    // Edge detect: A held in both polls, B added in the second
    pad_a0 = 8'(1 << BTN_A);
    pad_a1 = 8'h00;
    run_a(0, 1'b0, 80, v_cyc, v2_cyc, n_valid, latch_cyc, clk_rise, clk_hi,
          btn_v, pp_v, pp_off, btn_glitch, busy_after);
    chk("t6_buttons1", btn_v, 16'h0001);
    chk("t6_pressed1", pp_v, EDGE ? 16'h0001 : 16'h0);
    chk("t6_pressed1_off", pp_off, 0);
    pad_a0 = 8'((1 << BTN_A) | (1 << BTN_B));
    run_a(0, 1'b0, 80, v_cyc, v2_cyc, n_valid, latch_cyc, clk_rise, clk_hi,
          btn_v, pp_v, pp_off, btn_glitch, busy_after);
    chk("t6_buttons2", btn_v, 16'h0003);
    chk("t6_pressed2", pp_v, EDGE ? 16'h0002 : 16'h0);
    chk("t6_pressed2_off", pp_off, 0);
    chk("t6_valid_count", n_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
